// File: rtl/upstream_pkg.sv
// Shared definitions for the upstream alignment path.
//   state_t    control FSM encodings for upstream_aligner
//   QW_BYTES   bytes per datapath qword
//   head_mask  byte-enable mask for the first output qword (clears lanes below dst_off)
//   tail_mask  byte-enable mask for the last output qword (clears lanes at/above end_off)
package upstream_pkg;

  localparam int QW_BYTES = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic [QW_BYTES-1:0] head_mask(input logic [2:0] dst_off);
    return {QW_BYTES{1'b1}} << dst_off;
  endfunction

  // end_off == 0 means the payload ends exactly on a qword boundary, so no trim.
  function automatic logic [QW_BYTES-1:0] tail_mask(input logic [2:0] end_off);
    return (end_off == 3'd0) ? {QW_BYTES{1'b1}} : ~({QW_BYTES{1'b1}} << end_off);
  endfunction

endpackage

// File: rtl/upstream_shift128.sv
// Combinational byte funnel shifter: selects 8 consecutive bytes out of the
// 16-byte window {hi, lo}, starting at byte sh of lo.
//   hi   upper qword of the window (newer data)
//   lo   lower qword of the window (older data)
//   sh   byte shift amount 0..7
//   dout ({hi, lo} >> 8*sh)[63:0]
module upstream_shift128
  import upstream_pkg::*;
(
  input  logic [63:0] hi,
  input  logic [63:0] lo,
  input  logic [2:0]  sh,
  output logic [63:0] dout
);

  logic [2*QW_BYTES*8-1:0] window;
  logic [2*QW_BYTES*8-1:0] shifted;

  assign window  = {hi, lo};
  assign shifted = window >> {sh, 3'b000};
  assign dout    = shifted[63:0];

endmodule

// File: rtl/upstream_aligner.sv
// Byte realigner between upstream_ahbif and the upstream write FIFO.
// Takes 8-byte-aligned source qwords and re-packs them to the destination
// byte alignment, with head/tail byte enables and a one-qword residual flush.
//   clk, rst                 clock, asynchronous active-high reset
//   start / done             level request; done held until start drops
//   src_off, dst_off, length low address bits and payload byte count (static while start)
//   in_data/in_en/in_last    qword stream from ahbif
//   pause                    back-pressure to ahbif, derived from out_afull
//   out_data/out_be/out_en/out_last  realigned qword push into the FIFO
module upstream_aligner
  import upstream_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter bit PAUSE_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  input  logic [2:0]       src_off,
  input  logic [2:0]       dst_off,
  input  logic [LEN_W-1:0] length,
  input  logic [63:0]      in_data,
  input  logic             in_en,
  input  logic             in_last,
  output logic             pause,
  input  logic             out_afull,
  output logic [63:0]      out_data,
  output logic [7:0]       out_be,
  output logic             out_en,
  output logic             out_last
);

  localparam int CW = LEN_W + 1;

  state_t             state, state_d;
  logic [63:0]        hold, hold_d;
  logic               first, first_d;          // next accepted qword is the prime qword
  logic               first_out, first_out_d;  // next emitted qword gets the head mask
  logic [CW-1:0]      ocnt, ocnt_d;            // output qwords still owed
  logic               done_d;
  logic [63:0]        out_data_d;
  logic [7:0]         out_be_d;
  logic               out_en_d, out_last_d;

  logic [2:0]         sh;
  logic               prime;
  logic [CW-1:0]      span;
  logic [CW-1:0]      n_out;
  logic [2:0]         end_off;
  logic [63:0]        shift_hi;
  logic [63:0]        shifted;
  logic               take;
  logic [QW_BYTES-1:0] be_next;

  // Transfer geometry; operands are static for the whole transfer.
  assign sh      = src_off - dst_off;
  assign prime   = (src_off >= dst_off);
  assign span    = {1'b0, length} + CW'(dst_off) + CW'(7);
  assign n_out   = span >> 3;
  assign end_off = dst_off + length[2:0];

  // A final half-qword from ahbif arrives as in_last without in_en; treat it as data.
  assign take = in_en | in_last;

  // FLUSH drains the residual bytes of hold with zeros shifted in from above.
  assign shift_hi = (state == S_FLUSH) ? 64'd0 : in_data;

  upstream_shift128 u_shift (
    .hi   (shift_hi),
    .lo   (hold),
    .sh   (sh),
    .dout (shifted)
  );

  // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state;
    hold_d      = hold;
    first_d     = first;
    first_out_d = first_out;
    ocnt_d      = ocnt;
    done_d      = done;
    out_data_d  = out_data;
    out_be_d    = out_be;
    out_en_d    = 1'b0;
    out_last_d  = 1'b0;
    be_next     = {QW_BYTES{1'b1}};

    case (state)
      S_IDLE: begin
        if (start && !done) begin
          if (length != '0) begin
            state_d     = S_RUN;
            hold_d      = 64'd0;
            first_d     = prime;
            first_out_d = 1'b1;
            ocnt_d      = n_out;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (take) begin
          hold_d = in_data;
          if (first) begin
            // Prime qword only fills hold; its bytes leave with the next one.
            first_d = 1'b0;
          end else if (ocnt != '0) begin
            if (first_out) be_next = be_next & head_mask(dst_off);
            if (ocnt == CW'(1)) be_next = be_next & tail_mask(end_off);
            out_data_d  = shifted;
            out_be_d    = be_next;
            out_en_d    = 1'b1;
            first_out_d = 1'b0;
            ocnt_d      = ocnt - CW'(1);
          end
          if (in_last) begin
            if (ocnt_d == '0) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              out_last_d = out_en_d;
            end else begin
              state_d = S_FLUSH;
            end
          end
        end
      end

      S_FLUSH: begin
        if (first_out) be_next = be_next & head_mask(dst_off);
        be_next     = be_next & tail_mask(end_off);
        out_data_d  = shifted;
        out_be_d    = be_next;
        out_en_d    = 1'b1;
        out_last_d  = 1'b1;
        first_out_d = 1'b0;
        ocnt_d      = '0;
        state_d     = S_DONE;
        done_d      = 1'b1;
      end

      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the hold datapath register is reset along with control so a reset mid-transfer leaves no stale bytes to flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= 64'd0;
      first     <= 1'b0;
      first_out <= 1'b0;
      ocnt      <= '0;
      done      <= 1'b0;
      out_data  <= 64'd0;
      out_be    <= 8'd0;
      out_en    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state     <= state_d;
      hold      <= hold_d;
      first     <= first_d;
      first_out <= first_out_d;
      ocnt      <= ocnt_d;
      done      <= done_d;
      out_data  <= out_data_d;
      out_be    <= out_be_d;
      out_en    <= out_en_d;
      out_last  <= out_last_d;
    end
  end

  generate
    if (PAUSE_REG) begin : g_pause_reg
      logic pause_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pause_q <= 1'b0;
        else     pause_q <= out_afull;
      end
      assign pause = pause_q;
    end else begin : g_pause_comb
      assign pause = out_afull;
    end
  endgenerate

endmodule

// File: tb/tb_upstream_aligner.sv
// Scoreboard bench for upstream_aligner: stimulus pushes expected output
// qwords into a queue, a negedge monitor pops and compares on every out_en.
module tb_upstream_aligner;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             done;
  logic [2:0]       src_off;
  logic [2:0]       dst_off;
  logic [LEN_W-1:0] length;
  logic [63:0]      in_data;
  logic             in_en;
  logic             in_last;
  logic             pause;
  logic             out_afull;
  logic [63:0]      out_data;
  logic [7:0]       out_be;
  logic             out_en;
  logic             out_last;

  upstream_aligner #(.LEN_W(LEN_W), .PAUSE_REG(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .src_off   (src_off),
    .dst_off   (dst_off),
    .length    (length),
    .in_data   (in_data),
    .in_en     (in_en),
    .in_last   (in_last),
    .pause     (pause),
    .out_afull (out_afull),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_en    (out_en),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Monitor: compare every pushed qword against the head of the scoreboard.
  exp_t got_e;
  always @(negedge clk) begin
    if (!rst && out_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got data %h be %h last %0b, expected no output",
                 out_data, out_be, out_last);
      end else begin
        got_e = exp_q.pop_front();
        check("out_be", {56'd0, out_be}, {56'd0, got_e.be});
        check("out_data", out_data & be_mask(got_e.be), got_e.data & be_mask(got_e.be));
        check("out_last", {63'd0, out_last}, {63'd0, got_e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [63:0] d, input logic [7:0] be, input logic last);
    exp_t e;
    e.data = d;
    e.be   = be;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic begin_xfer(input logic [2:0] s, input logic [2:0] d, input logic [LEN_W-1:0] len);
    src_off = s;
    dst_off = d;
    length  = len;
    start   = 1'b1;
    tick();
  endtask

  task automatic send(input logic [63:0] d, input logic en, input logic last);
    in_data = d;
    in_en   = en;
    in_last = last;
    tick();
    in_en   = 1'b0;
    in_last = 1'b0;
  endtask

  // Wait (bounded) for done, let the monitor drain, then release start.
  task automatic finish_xfer(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    #1;
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    start = 1'b0;
    tick();
    tick();
    check({name, "_done_clr"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_t2();
    begin_xfer(3'd3, 3'd0, 16'd8);
    expect_out(64'h0A09_0807_0605_0403, 8'hFF, 1'b1);
    send(64'h0706_0504_0302_0100, 1'b1, 1'b0);
    send(64'h0F0E_0D0C_0B0A_0908, 1'b1, 1'b1);
    finish_xfer("t2", 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    src_off   = 3'd0;
    dst_off   = 3'd0;
    length    = '0;
    in_data   = 64'd0;
    in_en     = 1'b0;
    in_last   = 1'b0;
    out_afull = 1'b0;
    tick();
    tick();
    check("rst_out_en", {63'd0, out_en}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_be", {56'd0, out_be}, 64'd0);
    check("rst_done", {62'd0, out_last, done}, 64'd0);
    check("rst_pause", {63'd0, pause}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: aligned pass-through, two qwords.
    begin_xfer(3'd0, 3'd0, 16'd16);
    expect_out(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    expect_out(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    send(64'h1111_2222_3333_4444, 1'b1, 1'b0);
    send(64'h5555_6666_7777_8888, 1'b1, 1'b1);
    finish_xfer("t1", 10);

    // 2: source ahead of destination, prime qword suppresses the first output.
    run_t2();

    // 3: destination ahead, one input qword yields two outputs via flush.
    begin_xfer(3'd0, 3'd5, 16'd8);
    expect_out(64'h1211_1000_0000_0000, 8'hE0, 1'b0);
    expect_out(64'h0000_0017_1615_1413, 8'h1F, 1'b1);
    send(64'h1716_1514_1312_1110, 1'b1, 1'b1);
    finish_xfer("t3", 10);

    // 4: single output with both head and tail trimming.
    begin_xfer(3'd6, 3'd2, 16'd3);
    expect_out(64'h2B2A_2928_2726_2524, 8'h1C, 1'b1);
    send(64'h2726_2524_2322_2120, 1'b1, 1'b0);
    send(64'h2F2E_2D2C_2B2A_2928, 1'b1, 1'b1);
    finish_xfer("t4", 10);

    // 5: final half-qword signalled by in_last without in_en.
    begin_xfer(3'd0, 3'd0, 16'd12);
    expect_out(64'h3736_3534_3332_3130, 8'hFF, 1'b0);
    expect_out(64'hDEAD_BEEF_3B3A_3938, 8'h0F, 1'b1);
    send(64'h3736_3534_3332_3130, 1'b1, 1'b0);
    send(64'hDEAD_BEEF_3B3A_3938, 1'b0, 1'b1);
    finish_xfer("t5", 10);

    // 6a: zero length completes without output.
    begin_xfer(3'd1, 3'd4, 16'd0);
    finish_xfer("t6_len0", 1);

    // 6b: reset mid-transfer clears all outputs immediately.
    begin_xfer(3'd0, 3'd0, 16'd16);
    expect_out(64'hA5A5_0101_0202_0303, 8'hFF, 1'b0);
    send(64'hA5A5_0101_0202_0303, 1'b1, 1'b0);
    send(64'h5A5A_0404_0505_0606, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("t6_pre_rst_drained", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_out_data", out_data, 64'd0);
    check("t6_rst_out_be", {56'd0, out_be}, 64'd0);
    check("t6_rst_ctrl", {60'd0, out_en, out_last, done, pause}, 64'd0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_t2();

    // 6c: registered pause follows out_afull one cycle later.
    out_afull = 1'b1;
    #1;
    check("t6_pause_before_edge", {63'd0, pause}, 64'd0);
    tick();
    check("t6_pause_set", {63'd0, pause}, 64'd1);
    out_afull = 1'b0;
    tick();
    check("t6_pause_clr", {63'd0, pause}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
